// File: rtl/msg_cmd_decoder.sv
// Command decoder: accepts one command packet at a time, updates or reads the layer
// configuration registers or launches the layer engine, then returns one response packet.
module msg_cmd_decoder #(
  parameter int C_PACKET_WIDTH = 66,
  parameter int C_NUM_REGS     = 16,
  parameter int C_TIMEOUT      = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_accept,
  input  logic [C_PACKET_WIDTH-1:0]   cmd_data,
  output logic                        rsp_valid,
  input  logic                        rsp_accept,
  output logic [C_PACKET_WIDTH-1:0]   rsp_data,
  output logic [C_NUM_REGS*32-1:0]    cfg_regs,
  output logic                        layer_start,
  input  logic                        layer_done
);

  localparam int CNT_W = $clog2(C_TIMEOUT + 1);
  localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;

  localparam logic [7:0] STS_OK      = 8'h00;
  localparam logic [7:0] STS_BAD_IDX = 8'h01;
  localparam logic [7:0] STS_BAD_OP  = 8'h02;
  localparam logic [7:0] STS_TIMEOUT = 8'h03;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_DECODE    = 4'b0010,
    ST_EXEC_WAIT = 4'b0100,
    ST_RESP      = 4'b1000
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]       op_reg;
  logic [7:0]       idx_reg;
  logic [31:0]      wdata_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      regs [C_NUM_REGS];

  logic             idx_ok;
  logic [IDX_W-1:0] idx_sel;
  logic             timeout_hit;
  logic             unused_cmd_bits;

  assign idx_ok          = ({1'b0, idx_reg} < 9'(C_NUM_REGS));
  assign idx_sel         = idx_reg[IDX_W-1:0];
  assign timeout_hit     = (cnt_reg == CNT_W'(C_TIMEOUT - 1));
  assign unused_cmd_bits = ^cmd_data[55:32];

  function automatic logic [C_PACKET_WIDTH-1:0] make_rsp(input logic [1:0]  op,
                                                          input logic [7:0]  idx,
                                                          input logic [7:0]  status,
                                                          input logic [31:0] data);
    logic [C_PACKET_WIDTH-1:0] r;
    r          = '0;
    r[65:64]   = op;
    r[63:56]   = idx;
    r[55:48]   = status;
    r[31:0]    = data;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_accept = (state_reg == ST_IDLE);
    case (state_reg)
      ST_IDLE:      if (cmd_valid) state_next = ST_DECODE;
      ST_DECODE:    state_next = (op_reg == OP_START) ? ST_EXEC_WAIT : ST_RESP;
      ST_EXEC_WAIT: if (layer_done || timeout_hit) state_next = ST_RESP;
      ST_RESP:      if (rsp_valid && rsp_accept) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // The first ST_RESP cycle loads the output register; rsp_valid then holds until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg      <= '0;
      idx_reg     <= '0;
      wdata_reg   <= '0;
      cnt_reg     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      layer_start <= 1'b0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      layer_start <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg    <= cmd_data[65:64];
            idx_reg   <= cmd_data[63:56];
            wdata_reg <= cmd_data[31:0];
          end
        end
        ST_DECODE: begin
          case (op_reg)
            OP_WRITE: begin
              if (idx_ok) begin
                regs[idx_sel] <= wdata_reg;
                rsp_data      <= make_rsp(op_reg, idx_reg, STS_OK, wdata_reg);
              end else begin
                rsp_data <= make_rsp(op_reg, idx_reg, STS_BAD_IDX, 32'h0);
              end
            end
            OP_READ: begin
              if (idx_ok) begin
                rsp_data <= make_rsp(op_reg, idx_reg, STS_OK, regs[idx_sel]);
              end else begin
                rsp_data <= make_rsp(op_reg, idx_reg, STS_BAD_IDX, 32'h0);
              end
            end
            OP_START: begin
              cnt_reg     <= '0;
              layer_start <= 1'b1;
            end
            default: rsp_data <= make_rsp(op_reg, idx_reg, STS_BAD_OP, 32'h0);
          endcase
        end
        ST_EXEC_WAIT: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (layer_done) begin
            rsp_data <= make_rsp(op_reg, idx_reg, STS_OK, 32'(cnt_reg));
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (timeout_hit) begin
              rsp_data <= make_rsp(op_reg, idx_reg, STS_TIMEOUT, 32'(C_TIMEOUT));
            end
          end
        end
        ST_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_accept) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_cfg
    assign cfg_regs[gi*32 +: 32] = regs[gi];
  end

endmodule

// File: tb/tb_msg_cmd_decoder.sv
// Bench for msg_cmd_decoder: directed latency/format cases plus randomized traffic,
// all checked every cycle against a transaction-timeline model of the decoder.
module tb_msg_cmd_decoder;

  localparam int PW = 66;
  localparam int NR = 16;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_accept;
  logic [PW-1:0]  cmd_data = '0;
  logic           rsp_valid;
  logic           rsp_accept = 1'b0;
  logic [PW-1:0]  rsp_data;
  logic [NR*32-1:0] cfg_regs;
  logic           layer_start;
  logic           layer_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  msg_cmd_decoder #(
    .C_PACKET_WIDTH(PW),
    .C_NUM_REGS    (NR),
    .C_TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_accept (cmd_accept),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_accept (rsp_accept),
    .rsp_data   (rsp_data),
    .cfg_regs   (cfg_regs),
    .layer_start(layer_start),
    .layer_done (layer_done)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [65:0] pkt(input logic [1:0] op, input logic [7:0] idx,
                                      input logic [7:0] st, input logic [31:0] d);
    return {op, idx, st, 16'h0, d};
  endfunction

  function automatic logic [65:0] mk(input logic [1:0] op, input logic [7:0] idx, input logic [31:0] d);
    logic [23:0] junk;
    junk = 24'($urandom);
    return {op, idx, junk, d};
  endfunction

  // Model: edges counted from the handshake edge; decode at edge 1, response
  // visible one edge after it is decided, START waits on edges 2..TO+1.
  bit          m_busy = 0, m_rv = 0, m_ls = 0, m_wait = 0;
  int          m_n = 0, m_rsp_edge = -1;
  logic [65:0] m_cmd = '0, m_exp = '0;
  logic [31:0] m_regs [NR];

  initial begin : model
    logic [1:0]  op;
    logic [7:0]  idx;
    logic [31:0] d;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_rv = 0; m_ls = 0; m_wait = 0; m_n = 0; m_rsp_edge = -1; m_exp = '0;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
      end else if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_n = 0; m_cmd = cmd_data; m_rsp_edge = -1;
        end
      end else begin
        m_n++;
        m_ls = 0;
        op  = m_cmd[65:64];
        idx = m_cmd[63:56];
        d   = m_cmd[31:0];
        if (m_rv) begin
          if (rsp_accept) begin m_rv = 0; m_busy = 0; end
        end else if (m_n == m_rsp_edge) begin
          m_rv = 1;
        end else if (m_n == 1) begin
          m_rsp_edge = 2;
          case (op)
            2'b00: if (idx < NR) begin m_regs[idx[3:0]] = d; m_exp = pkt(op, idx, 8'h00, d); end
                   else m_exp = pkt(op, idx, 8'h01, 32'h0);
            2'b01: if (idx < NR) m_exp = pkt(op, idx, 8'h00, m_regs[idx[3:0]]);
                   else m_exp = pkt(op, idx, 8'h01, 32'h0);
            2'b10: begin m_wait = 1; m_ls = 1; m_rsp_edge = -1; end
            default: m_exp = pkt(op, idx, 8'h02, 32'h0);
          endcase
        end else if (m_wait) begin
          if (layer_done) begin
            m_exp = pkt(op, idx, 8'h00, 32'(m_n - 2)); m_wait = 0; m_rsp_edge = m_n + 1;
          end else if (m_n == TO + 1) begin
            m_exp = pkt(op, idx, 8'h03, 32'(TO)); m_wait = 0; m_rsp_edge = m_n + 1;
          end
        end
      end
    end
  end

  initial begin : compare
    logic [NR*32-1:0] flat;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_cmd_accept", 512'(cmd_accept), 512'(1));
        chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
        chk("rst_rsp_data", 512'(rsp_data), 512'(0));
        chk("rst_layer_start", 512'(layer_start), 512'(0));
        chk("rst_cfg_regs", 512'(cfg_regs), 512'(0));
      end else begin
        for (int i = 0; i < NR; i++) flat[i*32 +: 32] = m_regs[i];
        chk("cmd_accept", 512'(cmd_accept), 512'(!m_busy));
        chk("rsp_valid", 512'(rsp_valid), 512'(m_rv));
        if (m_rv) chk("rsp_data", 512'(rsp_data), 512'(m_exp));
        chk("layer_start", 512'(layer_start), 512'(m_ls));
        chk("cfg_regs", 512'(cfg_regs), 512'(flat));
      end
    end
  end

  // Issues one command; lat_v = edges from handshake to rsp_valid, lat_a = edges to cmd_accept.
  task automatic run_cmd(input logic [65:0] c, input int hold, input int done_dly,
                         output logic [65:0] rsp, output int lat_v, output int lat_a, output int starts);
    int n;
    int e;
    int ls_at;
    rsp = '0; lat_v = -1; lat_a = -1; starts = 0; ls_at = -1;
    n = 0;
    while (!cmd_accept && n < 100) begin @(posedge clk); #1; n++; end
    chk("idle_wait_bound", 512'(cmd_accept), 512'(1));
    cmd_valid  = 1'b1;
    cmd_data   = c;
    rsp_accept = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e = 0;
    while (e < 100 && lat_a < 0) begin
      if (layer_start) begin starts++; ls_at = e; end
      layer_done = (done_dly >= 0 && ls_at >= 0 && e == ls_at + done_dly);
      if (rsp_valid && lat_v < 0) begin lat_v = e; rsp = rsp_data; end
      else if (rsp_valid && e > lat_v) chk("rsp_stable", 512'(rsp_data), 512'(rsp));
      if (rsp_valid && e - lat_v >= hold) rsp_accept = 1'b1;
      @(posedge clk); #1; e++;
      if (cmd_accept && lat_v >= 0) lat_a = e;
    end
    chk("cmd_cycle_bound", 512'(lat_a >= 0), 512'(1));
    rsp_accept = 1'b0;
    layer_done = 1'b0;
  endtask

  initial begin : driver
    logic [65:0]  r;
    logic [511:0] e_cfg;
    int lv, la, ns;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_accept", 512'(cmd_accept), 512'(1));

    run_cmd(mk(2'b00, 8'd3, 32'hDEADBEEF), 0, -1, r, lv, la, ns);
    chk("wr3_rsp", 512'(r), 512'({2'b00, 8'd3, 8'h00, 16'h0, 32'hDEADBEEF}));
    chk("wr3_lat_valid", 512'(lv), 512'(2));
    chk("wr3_lat_accept", 512'(la), 512'(3));
    chk("wr3_cfg", 512'(cfg_regs[127:96]), 512'(32'hDEADBEEF));

    run_cmd(mk(2'b01, 8'd3, 32'h0), 0, -1, r, lv, la, ns);
    chk("rd3_rsp", 512'(r), 512'({2'b01, 8'd3, 8'h00, 16'h0, 32'hDEADBEEF}));

    run_cmd(mk(2'b01, 8'd16, 32'h1234), 0, -1, r, lv, la, ns);
    chk("rd16_rsp", 512'(r), 512'({2'b01, 8'd16, 8'h01, 16'h0, 32'h0}));
    e_cfg = '0;
    e_cfg[127:96] = 32'hDEADBEEF;
    chk("rd16_cfg_unchanged", 512'(cfg_regs), e_cfg);

    run_cmd(mk(2'b00, 8'd20, 32'h55AA55AA), 0, -1, r, lv, la, ns);
    chk("wr20_rsp", 512'(r), 512'({2'b00, 8'd20, 8'h01, 16'h0, 32'h0}));
    chk("wr20_cfg_unchanged", 512'(cfg_regs), e_cfg);

    run_cmd(mk(2'b10, 8'd7, 32'h0), 0, 5, r, lv, la, ns);
    chk("start_done_rsp", 512'(r), 512'({2'b10, 8'd7, 8'h00, 16'h0, 32'd5}));
    chk("start_done_pulses", 512'(ns), 512'(1));
    chk("start_done_lat", 512'(lv), 512'(8));

    run_cmd(mk(2'b10, 8'd9, 32'h0), 0, -1, r, lv, la, ns);
    chk("start_to_rsp", 512'(r), 512'({2'b10, 8'd9, 8'h03, 16'h0, 32'd8}));
    chk("start_to_pulses", 512'(ns), 512'(1));
    chk("start_to_lat", 512'(lv), 512'(10));
    layer_done = 1'b1;
    @(posedge clk); #1 layer_done = 1'b0;
    repeat (3) begin
      chk("late_done_no_rsp", 512'(rsp_valid), 512'(0));
      chk("late_done_idle", 512'(cmd_accept), 512'(1));
      @(posedge clk); #1;
    end

    run_cmd(mk(2'b11, 8'd2, 32'hFFFF), 4, -1, r, lv, la, ns);
    chk("badop_rsp", 512'(r), 512'({2'b11, 8'd2, 8'h02, 16'h0, 32'h0}));
    chk("badop_lat_accept", 512'(la), 512'(7));

    // Reset while waiting on the layer engine.
    cmd_valid = 1'b1;
    cmd_data  = mk(2'b10, 8'd5, 32'h0);
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 512'(rsp_valid), 512'(0));
    chk("mid_rst_rsp_data", 512'(rsp_data), 512'(0));
    chk("mid_rst_layer_start", 512'(layer_start), 512'(0));
    chk("mid_rst_cfg", 512'(cfg_regs), 512'(0));
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_release_accept", 512'(cmd_accept), 512'(1));
    layer_done = 1'b1;
    @(posedge clk); #1 layer_done = 1'b0;
    repeat (10) begin
      chk("mid_rst_no_rsp", 512'(rsp_valid), 512'(0));
      chk("mid_rst_no_start", 512'(layer_start), 512'(0));
      @(posedge clk); #1;
    end
    run_cmd(mk(2'b00, 8'd15, 32'h12345678), 0, -1, r, lv, la, ns);
    chk("post_rst_wr_rsp", 512'(r), 512'({2'b00, 8'd15, 8'h00, 16'h0, 32'h12345678}));
    chk("post_rst_wr_cfg", 512'(cfg_regs[511:480]), 512'(32'h12345678));

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_data   = mk(2'($urandom_range(0, 3)), 8'($urandom_range(0, 19)), $urandom);
      rsp_accept = 1'($urandom_range(0, 1));
      layer_done = ($urandom_range(0, 5) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0; rsp_accept = 1'b1; layer_done = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
